scarv_cop_cprs_wb: RTL

Write-back arbiter and sequencer for the COP general-purpose register file's single write port. Accepts write-back requests from NREQ COP functional units (ALU, memory, multi-precision) with valid/ready handshakes and grants one per cycle, round-robin. Expands 64-bit "pair" results into two consecutive register writes. Drives the register file's `crd_wen`/`crd_addr`/`crd_wdata` port from registers.

---
 rtl/scarv_cop_pkg.sv | 13 +
 rtl/scarv_cop_rr_arb.sv | 35 +++
 rtl/scarv_cop_cprs_wb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/scarv_cop_pkg.sv
// Shared COP definitions: write-back FSM encoding and register-file geometry.
package scarv_cop_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } wb_state_t;

    localparam int CPR_ADDR_W       = 4;
    localparam int CPR_DATA_W       = 32;
    localparam int COP_NREQ_DEFAULT = 3;

endpackage

// File: rtl/scarv_cop_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module scarv_cop_rr_arb #(
    parameter  int NREQ = 3,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // cand[k] is the requester examined k-th in priority order.
    logic [IW-1:0] cand [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(ptr) + gi) % NREQ);
        end
    endgenerate

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && en && req[cand[k]]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
        gnt = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/scarv_cop_cprs_wb.sv
// COP register-file write-back arbiter/sequencer; pair results become two beats.
// Optional hazard tracking on `pending` is enabled by SCARV_COP_CPRS_WB_HAZARD_EN.
module scarv_cop_cprs_wb
    import scarv_cop_pkg::*;
#(
    parameter int NREQ = COP_NREQ_DEFAULT
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    output logic                       g_clk_req,
    input  logic [NREQ-1:0]            rq_valid,
    output logic [NREQ-1:0]            rq_ready,
    input  logic [NREQ-1:0]            rq_pair,
    input  logic [CPR_ADDR_W*NREQ-1:0] rq_addr,
    input  logic [4*NREQ-1:0]          rq_wen,
    input  logic [CPR_DATA_W*NREQ-1:0] rq_wdata_lo,
    input  logic [CPR_DATA_W*NREQ-1:0] rq_wdata_hi,
    output logic [3:0]                 crd_wen,
    output logic [CPR_ADDR_W-1:0]      crd_addr,
    output logic [CPR_DATA_W-1:0]      crd_wdata,
    output logic                       busy,
    output logic [15:0]                pending
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wb_state_t             state_reg;
    logic [IW-1:0]         rr_ptr_reg;
    logic [3:0]            crd_wen_reg;
    logic [CPR_ADDR_W-1:0] crd_addr_reg;
    logic [CPR_DATA_W-1:0] crd_wdata_reg;
    logic [3:0]            hi_wen_reg;
    logic [CPR_ADDR_W-1:0] hi_addr_reg;
    logic [CPR_DATA_W-1:0] hi_data_reg;

    logic [CPR_ADDR_W-1:0] addr_arr [NREQ];
    logic [3:0]            wen_arr  [NREQ];
    logic [CPR_DATA_W-1:0] lo_arr   [NREQ];
    logic [CPR_DATA_W-1:0] hi_arr   [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
            assign addr_arr[gi] = rq_addr[CPR_ADDR_W*gi +: CPR_ADDR_W];
            assign wen_arr[gi]  = rq_wen[4*gi +: 4];
            assign lo_arr[gi]   = rq_wdata_lo[CPR_DATA_W*gi +: CPR_DATA_W];
            assign hi_arr[gi]   = rq_wdata_hi[CPR_DATA_W*gi +: CPR_DATA_W];
        end
    endgenerate

    logic          arb_en;
    logic          arb_any;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] ptr_next;

    // Granting is suppressed during reset and while the second beat is in flight.
    assign arb_en   = g_resetn && (state_reg == ST_IDLE);
    assign ptr_next = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    scarv_cop_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .req (rq_valid),
        .ptr (rr_ptr_reg),
        .en  (arb_en),
        .gnt (rq_ready),
        .idx (gnt_idx),
        .any (arb_any)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            crd_wen_reg   <= '0;
            crd_addr_reg  <= '0;
            crd_wdata_reg <= '0;
            hi_wen_reg    <= '0;
            hi_addr_reg   <= '0;
            hi_data_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        crd_wen_reg   <= wen_arr[gnt_idx];
                        crd_addr_reg  <= addr_arr[gnt_idx];
                        crd_wdata_reg <= lo_arr[gnt_idx];
                        rr_ptr_reg    <= ptr_next;
                        if (rq_pair[gnt_idx]) begin
                            // Address arithmetic wraps naturally at 4 bits (15 -> 0).
                            hi_wen_reg  <= wen_arr[gnt_idx];
                            hi_addr_reg <= addr_arr[gnt_idx] + 1'b1;
                            hi_data_reg <= hi_arr[gnt_idx];
                            state_reg   <= ST_BEAT2;
                        end
                    end else begin
                        crd_wen_reg <= '0;
                    end
                end
                ST_BEAT2: begin
                    crd_wen_reg   <= hi_wen_reg;
                    crd_addr_reg  <= hi_addr_reg;
                    crd_wdata_reg <= hi_data_reg;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign crd_wen   = crd_wen_reg;
    assign crd_addr  = crd_addr_reg;
    assign crd_wdata = crd_wdata_reg;
    assign busy      = (state_reg == ST_BEAT2);
    assign g_clk_req = (|crd_wen_reg) | busy | (|rq_valid);

`ifdef SCARV_COP_CPRS_WB_HAZARD_EN
    // Marks the beat on the write port plus the queued second beat.
    always_comb begin
        pending = '0;
        if (|crd_wen_reg)
            pending[crd_addr_reg] = 1'b1;
        if (busy && (|hi_wen_reg))
            pending[hi_addr_reg] = 1'b1;
    end
`else
    assign pending = 16'b0;
`endif

endmodule
